array_2b_rw_arbiter: RTL and testbench

Single-port access controller for the 256-entry × 2-bit masked SRAM macro used for saturating-counter tables. It sweeps the array to a known value after reset and arbitrates between a prediction read port and an update write port, both sharing the one RW port. Pending updates sit in a one-entry coalescing write buffer. Reads have priority over buffered writes, with a bounded starvation limit, and reads that hit the buffered index are bypassed.

---
 rtl/array_2b_rw_arbiter.sv | 134 +++++++++++++
 tb/tb_array_2b_rw_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_2b_rw_arbiter.sv
// Single-port access controller for a 2^IDX_W x DATA_W masked SRAM: init sweep after reset,
// then read-priority arbitration against a one-entry coalescing write buffer with read bypass.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping INIT_VAL into every entry, no requests accepted
// ST_RUN  | serving reads; buffered write drains on idle or forced
module array_2b_rw_arbiter #(
  parameter int                 IDX_W     = 8,
  parameter int                 DATA_W    = 2,
  parameter logic [DATA_W-1:0]  INIT_VAL  = DATA_W'(1),
  parameter int                 MAX_STALL = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [IDX_W-1:0]  r_idx,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [DATA_W-1:0] w_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [IDX_W-1:0]  sram_addr,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int SW    = $clog2(MAX_STALL + 1);
  localparam logic [IDX_W:0]  LAST_PTR  = (IDX_W + 1)'(DEPTH - 1);
  localparam logic [SW-1:0]   STALL_MAX = SW'(MAX_STALL);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W:0]      init_ptr_q;
  logic                buf_v_q;
  logic [IDX_W-1:0]    buf_idx_q;
  logic [DATA_W-1:0]   buf_data_q;
  logic [SW-1:0]       stall_q;
  logic                resp_v_q;
  logic                resp_byp_q;
  logic [DATA_W-1:0]   resp_byp_data_q;

  logic run, force_drain, r_fire, w_fire, drain;

  // Outputs are gated by reset so the reset cycle itself is quiet.
  assign run         = (state_q == ST_RUN) && !reset;
  assign force_drain = buf_v_q && (stall_q == STALL_MAX);
  assign r_ready     = run && !force_drain;
  assign r_fire      = r_valid && r_ready;
  assign drain       = run && buf_v_q && !r_fire;
  assign w_ready     = run && (!buf_v_q || drain || (w_idx == buf_idx_q));
  assign w_fire      = w_valid && w_ready;
  assign init_done   = run;

  always_comb begin
    state_d    = state_q;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!reset) begin
      case (state_q)
        ST_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_ptr_q[IDX_W-1:0];
          sram_wdata = INIT_VAL;
          if (init_ptr_q == LAST_PTR) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (r_fire) begin
            sram_en   = 1'b1;
            sram_addr = r_idx;
          end else if (drain) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = buf_idx_q;
            sram_wdata = buf_data_q;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign sram_wmask = sram_wmode;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_INIT;
      init_ptr_q      <= '0;
      buf_v_q         <= 1'b0;
      buf_idx_q       <= '0;
      buf_data_q      <= '0;
      stall_q         <= '0;
      resp_v_q        <= 1'b0;
      resp_byp_q      <= 1'b0;
      resp_byp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_ptr_q <= init_ptr_q + 1'b1;

      // A new write wins over drain: drain+accept leaves the new entry buffered.
      if (w_fire) begin
        buf_v_q    <= 1'b1;
        buf_idx_q  <= w_idx;
        buf_data_q <= w_data;
      end else if (drain) begin
        buf_v_q <= 1'b0;
      end

      if (drain || !buf_v_q)          stall_q <= '0;
      else if (stall_q != STALL_MAX)  stall_q <= stall_q + 1'b1;

      resp_v_q <= r_fire;
      if (r_fire) begin
        resp_byp_q      <= buf_v_q && (buf_idx_q == r_idx);
        resp_byp_data_q <= buf_data_q;
      end
    end
  end

  assign resp_valid = resp_v_q && !reset;
  assign resp_data  = !resp_valid ? '0 : (resp_byp_q ? resp_byp_data_q : sram_rdata);

endmodule

// File: tb/tb_array_2b_rw_arbiter.sv
// Bench for array_2b_rw_arbiter: an architectural memory model (last accepted write per index)
// predicts every read response; a behavioural SRAM macro model backs the DUT.
module tb_array_2b_rw_arbiter;

  localparam int MAX_STALL = 4;

  logic       clock;
  logic       reset;
  logic       init_done;
  logic       r_valid;
  logic       r_ready;
  logic [7:0] r_idx;
  logic       resp_valid;
  logic [1:0] resp_data;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] w_idx;
  logic [1:0] w_data;
  logic       sram_en;
  logic       sram_wmode;
  logic [7:0] sram_addr;
  logic       sram_wmask;
  logic [1:0] sram_wdata;
  logic [1:0] sram_rdata;

  array_2b_rw_arbiter dut (
    .clock(clock), .reset(reset), .init_done(init_done),
    .r_valid(r_valid), .r_ready(r_ready), .r_idx(r_idx),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx), .w_data(w_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM macro: masked write, registered read.
  logic [1:0] sram_mem [256];
  int         wr_cnt   [256];
  initial foreach (wr_cnt[k]) wr_cnt[k] = 0;
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        if (sram_wmask) sram_mem[sram_addr] <= sram_wdata;
        wr_cnt[sram_addr] <= wr_cnt[sram_addr] + 1;
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] ref_mem [256];
  logic       pend_v = 1'b0;
  logic [1:0] pend_d = 2'b00;
  logic       exp_rv;
  logic [1:0] exp_rd;
  logic       s_en, s_wmode, s_wmask, s_init_done, s_r_ready, s_w_ready, s_resp_valid;
  logic [7:0] s_addr;
  logic [1:0] s_wdata, s_resp_data;

  // One clock cycle: sample at negedge, update the reference model from accepted handshakes.
  task automatic cyc();
    @(negedge clock);
    s_en = sram_en; s_wmode = sram_wmode; s_wmask = sram_wmask; s_addr = sram_addr;
    s_wdata = sram_wdata; s_init_done = init_done; s_r_ready = r_ready; s_w_ready = w_ready;
    s_resp_valid = resp_valid; s_resp_data = resp_data;
    exp_rv = pend_v && !reset;
    exp_rd = pend_d;
    if (reset) begin
      foreach (ref_mem[k]) ref_mem[k] = 2'b01;
      pend_v = 1'b0;
    end else begin
      pend_v = r_valid && s_r_ready;
      pend_d = ref_mem[r_idx];
      if (w_valid && s_w_ready) ref_mem[w_idx] = w_data;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    r_valid = 1'b0; w_valid = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic check_init_sweep();
    for (int i = 0; i < 256; i++) begin
      cyc();
      n_tests++;
      if ({s_en, s_wmode, s_wmask, s_addr, s_wdata, s_init_done, s_r_ready, s_w_ready} !==
          {1'b1, 1'b1, 1'b1, 8'(i), 2'b01, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL init_sweep cyc=%0d en=%b wm=%b mask=%b addr=%0d wdata=%0d done=%b rr=%b wr=%b exp addr=%0d",
                 i, s_en, s_wmode, s_wmask, s_addr, s_wdata, s_init_done, s_r_ready, s_w_ready, i);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; r_valid = 1'b1; w_valid = 1'b1; r_idx = 8'h7F; w_idx = 8'h7F; w_data = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_tests++;
      if ({s_init_done, s_r_ready, s_w_ready, s_resp_valid, s_resp_data, s_en} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d done=%b rr=%b wr=%b rv=%b rd=%0d en=%b exp all 0",
                 k, s_init_done, s_r_ready, s_w_ready, s_resp_valid, s_resp_data, s_en);
      end
    end
    reset = 1'b0; r_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic test_init();
    check_init_sweep();
    r_valid = 1'b1; r_idx = 8'h7F;
    cyc();
    n_tests++;
    if ({s_init_done, s_r_ready, s_w_ready, s_en, s_wmode, s_addr} !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7F}) begin
      n_fail++;
      $display("FAIL init_done_ready done=%b rr=%b wr=%b en=%b wm=%b addr=%h exp 1 1 1 1 0 7f",
               s_init_done, s_r_ready, s_w_ready, s_en, s_wmode, s_addr);
    end
    r_valid = 1'b0;
    cyc();
    n_tests++;
    if (s_resp_valid !== 1'b1 || s_resp_data !== 2'b01) begin
      n_fail++;
      $display("FAIL init_read_7f rv=%b rd=%0d exp rv=1 rd=1", s_resp_valid, s_resp_data);
    end
  endtask

  task automatic test_bypass();
    idle(2);
    w_valid = 1'b1; w_idx = 8'd5; w_data = 2'd3;
    cyc();
    n_tests++;
    if (s_w_ready !== 1'b1) begin
      n_fail++; $display("FAIL bypass_w_accept w_ready=%b exp 1", s_w_ready);
    end
    w_valid = 1'b0; r_valid = 1'b1; r_idx = 8'd5;
    cyc();
    n_tests++;
    if ({s_r_ready, s_en, s_wmode} !== 3'b110) begin
      n_fail++; $display("FAIL bypass_read_prio rr=%b en=%b wm=%b exp 1 1 0", s_r_ready, s_en, s_wmode);
    end
    r_valid = 1'b0;
    cyc();
    n_tests++;
    if (s_resp_valid !== 1'b1 || s_resp_data !== 2'd3 || s_resp_data !== exp_rd) begin
      n_fail++; $display("FAIL bypass_data rv=%b rd=%0d exp rv=1 rd=3", s_resp_valid, s_resp_data);
    end
    n_tests++;
    if ({s_en, s_wmode, s_addr, s_wdata} !== {1'b1, 1'b1, 8'd5, 2'd3}) begin
      n_fail++; $display("FAIL bypass_drain en=%b wm=%b addr=%0d wd=%0d exp 1 1 5 3", s_en, s_wmode, s_addr, s_wdata);
    end
    r_valid = 1'b1; r_idx = 8'd5;
    cyc();
    r_valid = 1'b0;
    cyc();
    n_tests++;
    if (s_resp_valid !== 1'b1 || s_resp_data !== 2'd3 || sram_mem[5] !== 2'd3) begin
      n_fail++; $display("FAIL bypass_sram_read rv=%b rd=%0d mem=%0d exp rv=1 rd=3 mem=3",
                         s_resp_valid, s_resp_data, sram_mem[5]);
    end
  endtask

  task automatic test_starvation();
    idle(2);
    w_valid = 1'b1; w_idx = 8'd9; w_data = 2'd1;
    cyc();
    w_valid = 1'b0; r_valid = 1'b1;
    for (int k = 1; k <= MAX_STALL + 2; k++) begin
      r_idx = 8'($urandom_range(16, 255));
      cyc();
      n_tests++;
      if (s_r_ready !== (k != MAX_STALL + 1) || s_resp_valid !== exp_rv || (exp_rv && s_resp_data !== exp_rd)) begin
        n_fail++;
        $display("FAIL starve_ready k=%0d rr=%b rv=%b rd=%0d exp rr=%b rv=%b rd=%0d",
                 k, s_r_ready, s_resp_valid, s_resp_data, k != MAX_STALL + 1, exp_rv, exp_rd);
      end
      if (k == MAX_STALL + 1) begin
        n_tests++;
        if ({s_en, s_wmode, s_addr, s_wdata} !== {1'b1, 1'b1, 8'd9, 2'd1}) begin
          n_fail++; $display("FAIL starve_drain en=%b wm=%b addr=%0d wd=%0d exp 1 1 9 1", s_en, s_wmode, s_addr, s_wdata);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_coalesce();
    int c0;
    idle(2);
    c0 = wr_cnt[9];
    w_valid = 1'b1; w_idx = 8'd9; w_data = 2'd1; r_valid = 1'b1; r_idx = 8'h10;
    cyc();
    w_data = 2'd2; r_idx = 8'h11;
    cyc();
    n_tests++;
    if ({s_w_ready, s_r_ready, s_en, s_wmode} !== 4'b1110) begin
      n_fail++; $display("FAIL coalesce_accept wr=%b rr=%b en=%b wm=%b exp 1 1 1 0", s_w_ready, s_r_ready, s_en, s_wmode);
    end
    w_valid = 1'b0;
    for (int k = 0; k < MAX_STALL; k++) begin
      r_idx = 8'(8'h12 + k);
      cyc();
    end
    idle(3);
    n_tests++;
    if (wr_cnt[9] - c0 !== 1 || sram_mem[9] !== 2'd2) begin
      n_fail++; $display("FAIL coalesce_writes count=%0d mem=%0d exp count=1 mem=2", wr_cnt[9] - c0, sram_mem[9]);
    end
  endtask

  task automatic test_back_to_back();
    idle(2);
    w_valid = 1'b1; w_idx = 8'd3; w_data = 2'd2; r_valid = 1'b1; r_idx = 8'h20;
    cyc();
    w_idx = 8'd4; w_data = 2'd1;
    for (int k = 1; k <= MAX_STALL + 1; k++) begin
      r_idx = 8'($urandom_range(32, 255));
      cyc();
      n_tests++;
      if (s_w_ready !== (k == MAX_STALL + 1)) begin
        n_fail++; $display("FAIL b2b_w_ready k=%0d wr=%b exp %b", k, s_w_ready, k == MAX_STALL + 1);
      end
      if (k == MAX_STALL + 1) begin
        n_tests++;
        if ({s_en, s_wmode, s_addr, s_wdata} !== {1'b1, 1'b1, 8'd3, 2'd2}) begin
          n_fail++; $display("FAIL b2b_drain en=%b wm=%b addr=%0d wd=%0d exp 1 1 3 2", s_en, s_wmode, s_addr, s_wdata);
        end
      end
    end
    idle(3);
    n_tests++;
    if (sram_mem[3] !== 2'd2 || sram_mem[4] !== 2'd1) begin
      n_fail++; $display("FAIL b2b_mem mem3=%0d mem4=%0d exp 2 1", sram_mem[3], sram_mem[4]);
    end
  endtask

  task automatic test_random();
    int errs;
    idle(2);
    for (int k = 0; k < 400; k++) begin
      r_valid = 1'($urandom_range(0, 1));
      w_valid = ($urandom_range(0, 2) == 0);
      r_idx   = 8'($urandom_range(0, 7));
      w_idx   = 8'($urandom_range(0, 7));
      w_data  = 2'($urandom_range(0, 3));
      cyc();
      n_tests++;
      if (s_resp_valid !== exp_rv || (exp_rv && s_resp_data !== exp_rd)) begin
        n_fail++; $display("FAIL random_resp k=%0d rv=%b rd=%0d exp rv=%b rd=%0d", k, s_resp_valid, s_resp_data, exp_rv, exp_rd);
      end
    end
    idle(3);
    errs = 0;
    foreach (ref_mem[i]) if (sram_mem[i] !== ref_mem[i]) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++; $display("FAIL random_final_mem mismatching entries=%0d exp 0", errs);
    end
  endtask

  task automatic test_reset_midrun();
    idle(2);
    w_valid = 1'b1; w_idx = 8'd20; w_data = 2'd3; r_valid = 1'b1; r_idx = 8'd21;
    cyc();
    w_valid = 1'b0; r_idx = 8'd22;
    cyc();
    n_tests++;
    if (s_r_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_read_accept rr=%b exp 1", s_r_ready);
    end
    reset = 1'b1; r_valid = 1'b0;
    cyc();
    n_tests++;
    if (s_resp_valid !== 1'b0 || s_en !== 1'b0 || exp_rv !== 1'b0) begin
      n_fail++; $display("FAIL midrst_suppress rv=%b en=%b exp 0 0", s_resp_valid, s_en);
    end
    reset = 1'b0;
    check_init_sweep();
    r_valid = 1'b1; r_idx = 8'd20;
    cyc();
    r_valid = 1'b0;
    cyc();
    n_tests++;
    if (s_resp_valid !== 1'b1 || s_resp_data !== 2'b01 || sram_mem[20] !== 2'b01) begin
      n_fail++; $display("FAIL midrst_discard rv=%b rd=%0d mem=%0d exp 1 1 1", s_resp_valid, s_resp_data, sram_mem[20]);
    end
  endtask

  initial begin
    reset = 1'b1; r_valid = 1'b0; w_valid = 1'b0;
    r_idx = '0; w_idx = '0; w_data = '0;
    foreach (ref_mem[k]) ref_mem[k] = 2'b01;
    test_reset();
    test_init();
    test_bypass();
    test_starvation();
    test_coalesce();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
